// File: rtl/clk_div_ctrl.sv
// Runtime-programmable 50%-duty clock divider with a 4-phase req/ack ratio update
// that is only applied at a falling edge of clk_out (or while idle), so clk_out never glitches.
module clk_div_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] div_val,
  input  logic             cfg_req,
  output logic             cfg_ack,
  output logic             clk_out,
  output logic             clk_rise,
  output logic [CNT_W-1:0] div_active,
  output logic             busy
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_active_half;
  logic [CNT_W-1:0] r_pend_half;
  logic             r_pend_valid;
  logic             r_clk_out;
  logic             r_clk_rise;
  logic             r_cfg_ack;

  logic             w_wrap;
  logic             w_counting;
  logic             w_toggle;
  logic             w_rise;
  logic             w_fall;
  logic             w_apply;
  logic             w_capture;
  logic [CNT_W-1:0] w_pend_init;

  assign w_wrap = (r_cnt == r_active_half - ONE);

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: if (en) w_next_state = RUN;
      // A falling toggle on the same edge en drops lands straight in IDLE.
      RUN: begin
        if (!en) begin
          if (!r_clk_out || w_wrap) w_next_state = IDLE;
          else                      w_next_state = STOP;
        end
      end
      STOP: begin
        if (en)          w_next_state = RUN;
        else if (w_wrap) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    w_counting  = ((r_state == RUN) && (en || r_clk_out)) || (r_state == STOP);
    w_toggle    = w_counting && w_wrap;
    w_rise      = w_toggle && !r_clk_out;
    w_fall      = w_toggle && r_clk_out;
    // pend_valid must already be set, so a same-edge capture waits for the next fall.
    w_apply     = r_pend_valid && (w_fall || (r_state == IDLE));
    w_capture   = cfg_req && !r_cfg_ack && !r_pend_valid;
    w_pend_init = (div_val == '0) ? ONE : div_val;
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_cnt         <= '0;
      r_clk_out     <= 1'b0;
      r_clk_rise    <= 1'b0;
      r_cfg_ack     <= 1'b0;
      r_active_half <= ONE;
      r_pend_valid  <= 1'b0;
    end else begin
      r_cnt      <= (!w_counting || w_wrap || w_apply) ? '0 : r_cnt + ONE;
      r_clk_out  <= w_toggle ? !r_clk_out : r_clk_out;
      r_clk_rise <= w_rise;
      if (w_apply) begin
        r_active_half <= r_pend_half;
        r_pend_valid  <= 1'b0;
        r_cfg_ack     <= 1'b1;
      end else begin
        if (w_capture) r_pend_valid <= 1'b1;
        if (!cfg_req)  r_cfg_ack    <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (w_capture) r_pend_half <= w_pend_init;
  end

  assign cfg_ack    = r_cfg_ack;
  assign clk_out    = r_clk_out;
  assign clk_rise   = r_clk_rise;
  assign div_active = r_active_half;
  assign busy       = r_pend_valid;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Scoreboard bench for clk_div_ctrl: expected per-cycle outputs are queued from
// the timing rules when stimulus is applied and popped as each clk_in edge completes.
module tb_clk_div_ctrl;

  logic       clk_in;
  logic       rst;
  logic       en;
  logic [7:0] div_val;
  logic       cfg_req;
  logic       cfg_ack;
  logic       clk_out;
  logic       clk_rise;
  logic [7:0] div_active;
  logic       busy;

  typedef struct {
    logic       out;
    logic       rise;
    logic       ack;
    logic       bsy;
    logic [7:0] act;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  clk_div_ctrl #(.CNT_W(8)) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .en        (en),
    .div_val   (div_val),
    .cfg_req   (cfg_req),
    .cfg_ack   (cfg_ack),
    .clk_out   (clk_out),
    .clk_rise  (clk_rise),
    .div_active(div_active),
    .busy      (busy)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got running want finished");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; cfg_req = 1'b0; div_val = 8'd0;
    tick();
    rst = 1'b0;
  endtask

  task automatic set_ratio_idle(input logic [7:0] n);
    en = 1'b0; cfg_req = 1'b1; div_val = n;
    tick();
    tick();
    cfg_req = 1'b0;
    tick();
  endtask

  task automatic wait_rise(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      tick();
      if (clk_rise) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; cfg_req = 1'b0; div_val = 8'd0;
    #1;
    n_tests++; if (clk_out !== 1'b0)    begin n_fail++; $display("FAIL reset_clk_out: got %b want 0", clk_out); end
    n_tests++; if (clk_rise !== 1'b0)   begin n_fail++; $display("FAIL reset_clk_rise: got %b want 0", clk_rise); end
    n_tests++; if (cfg_ack !== 1'b0)    begin n_fail++; $display("FAIL reset_cfg_ack: got %b want 0", cfg_ack); end
    n_tests++; if (div_active !== 8'd1) begin n_fail++; $display("FAIL reset_div_active: got %0d want 1", div_active); end
    n_tests++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_div2();
    exp_t e;
    do_reset();
    q.delete();
    en = 1'b1;
    for (int m = 0; m < 10; m++) begin
      e.out = ((m / 1) % 2) == 1; e.rise = (m % 2) == 1;
      e.ack = 1'b0; e.bsy = 1'b0; e.act = 8'd1;
      q.push_back(e);
    end
    for (int m = 0; m < 10; m++) begin
      tick();
      e = q.pop_front();
      n_tests++;
      if ({clk_out, clk_rise} !== {e.out, e.rise} || div_active !== e.act) begin
        n_fail++;
        $display("FAIL div2 edge %0d: got out=%b rise=%b act=%0d want out=%b rise=%b act=%0d",
                 m, clk_out, clk_rise, div_active, e.out, e.rise, e.act);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_idle_ratio();
    exp_t e;
    do_reset();
    q.delete();
    en = 1'b0; cfg_req = 1'b1; div_val = 8'd3;
    tick();
    n_tests++; if ({busy, cfg_ack} !== 2'b10) begin n_fail++; $display("FAIL idle_capture: got busy=%b ack=%b want busy=1 ack=0", busy, cfg_ack); end
    tick();
    n_tests++;
    if ({busy, cfg_ack} !== 2'b01 || div_active !== 8'd3) begin
      n_fail++;
      $display("FAIL idle_apply: got busy=%b ack=%b act=%0d want busy=0 ack=1 act=3", busy, cfg_ack, div_active);
    end
    cfg_req = 1'b0; en = 1'b1;
    for (int m = 0; m < 14; m++) begin
      e.out = ((m / 3) % 2) == 1; e.rise = (m % 6) == 3;
      e.ack = 1'b0; e.bsy = 1'b0; e.act = 8'd3;
      q.push_back(e);
    end
    for (int m = 0; m < 14; m++) begin
      tick();
      e = q.pop_front();
      n_tests++;
      if ({clk_out, clk_rise, cfg_ack} !== {e.out, e.rise, e.ack}) begin
        n_fail++;
        $display("FAIL idle_ratio_run edge %0d: got out=%b rise=%b ack=%b want out=%b rise=%b ack=%b",
                 m, clk_out, clk_rise, cfg_ack, e.out, e.rise, e.ack);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_run_change();
    exp_t e;
    bit   ok;
    do_reset();
    q.delete();
    set_ratio_idle(8'd4);
    en = 1'b1;
    wait_rise(ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL run_change_start: got no rise want rise within 64 edges"); end
    tick();
    cfg_req = 1'b1; div_val = 8'd2;
    for (int m = 2; m < 14; m++) begin
      e.out  = (m < 4) ? 1'b1 : (((m - 4) / 2) % 2) == 1;
      e.rise = (m >= 4) && (((m - 4) % 4) == 2);
      e.bsy  = (m < 4);
      e.ack  = (m >= 4);
      e.act  = (m < 4) ? 8'd4 : 8'd2;
      q.push_back(e);
    end
    for (int m = 2; m < 14; m++) begin
      tick();
      e = q.pop_front();
      n_tests++;
      if ({clk_out, clk_rise, busy, cfg_ack} !== {e.out, e.rise, e.bsy, e.ack} || div_active !== e.act) begin
        n_fail++;
        $display("FAIL run_change edge %0d: got out=%b rise=%b busy=%b ack=%b act=%0d want out=%b rise=%b busy=%b ack=%b act=%0d",
                 m, clk_out, clk_rise, busy, cfg_ack, div_active, e.out, e.rise, e.bsy, e.ack, e.act);
      end
    end
    cfg_req = 1'b0;
    tick();
    n_tests++; if (cfg_ack !== 1'b0) begin n_fail++; $display("FAIL run_change_ack_clear: got %b want 0", cfg_ack); end
    en = 1'b0;
  endtask

  task automatic test_zero_early_drop();
    exp_t e;
    bit   ok;
    int   ack_cycles;
    do_reset();
    q.delete();
    set_ratio_idle(8'd5);
    en = 1'b1;
    wait_rise(ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL zero_start: got no rise want rise within 64 edges"); end
    cfg_req = 1'b1; div_val = 8'd0;
    for (int m = 1; m < 11; m++) begin
      e.out  = (m < 5) ? 1'b1 : ((m - 5) % 2) == 1;
      e.rise = (m >= 5) && (((m - 5) % 2) == 1);
      e.ack  = (m == 5);
      e.bsy  = (m < 5);
      e.act  = (m < 5) ? 8'd5 : 8'd1;
      q.push_back(e);
    end
    ack_cycles = 0;
    for (int m = 1; m < 11; m++) begin
      tick();
      if (m == 1) cfg_req = 1'b0;
      if (cfg_ack) ack_cycles++;
      e = q.pop_front();
      n_tests++;
      if ({clk_out, clk_rise, busy, cfg_ack} !== {e.out, e.rise, e.bsy, e.ack} || div_active !== e.act) begin
        n_fail++;
        $display("FAIL zero_drop edge %0d: got out=%b rise=%b busy=%b ack=%b act=%0d want out=%b rise=%b busy=%b ack=%b act=%0d",
                 m, clk_out, clk_rise, busy, cfg_ack, div_active, e.out, e.rise, e.bsy, e.ack, e.act);
      end
    end
    n_tests++; if (ack_cycles != 1) begin n_fail++; $display("FAIL zero_ack_width: got %0d cycles want 1", ack_cycles); end
    en = 1'b0;
  endtask

  task automatic test_stop_mid_high();
    exp_t e;
    bit   ok;
    do_reset();
    q.delete();
    set_ratio_idle(8'd6);
    en = 1'b1;
    wait_rise(ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL stop_start: got no rise want rise within 64 edges"); end
    tick();
    en = 1'b0;
    for (int m = 2; m < 12; m++) begin
      e.out = (m < 6); e.rise = 1'b0; e.ack = 1'b0; e.bsy = 1'b0; e.act = 8'd6;
      q.push_back(e);
    end
    for (int m = 2; m < 12; m++) begin
      tick();
      e = q.pop_front();
      n_tests++;
      if ({clk_out, clk_rise} !== {e.out, e.rise}) begin
        n_fail++;
        $display("FAIL stop_tail edge %0d: got out=%b rise=%b want out=%b rise=%b", m, clk_out, clk_rise, e.out, e.rise);
      end
    end
    en = 1'b1;
    wait_rise(ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL stop_restart: got no rise want rise within 64 edges"); end
    tick();
    en = 1'b0;
    for (int m = 2; m < 21; m++) begin
      e.out = ((m / 6) % 2) == 0; e.rise = (m % 12) == 0; e.ack = 1'b0; e.bsy = 1'b0; e.act = 8'd6;
      q.push_back(e);
    end
    for (int m = 2; m < 21; m++) begin
      tick();
      if (m == 2) en = 1'b1;
      e = q.pop_front();
      n_tests++;
      if ({clk_out, clk_rise} !== {e.out, e.rise}) begin
        n_fail++;
        $display("FAIL stop_resume edge %0d: got out=%b rise=%b want out=%b rise=%b", m, clk_out, clk_rise, e.out, e.rise);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_async_reset();
    bit ok;
    do_reset();
    set_ratio_idle(8'd7);
    en = 1'b1;
    wait_rise(ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL areset_start: got no rise want rise within 64 edges"); end
    cfg_req = 1'b1; div_val = 8'd3;
    tick();
    n_tests++; if ({clk_out, busy} !== 2'b11) begin n_fail++; $display("FAIL areset_pre: got out=%b busy=%b want out=1 busy=1", clk_out, busy); end
    #3;
    rst = 1'b1;
    #1;
    n_tests++;
    if ({clk_out, clk_rise, cfg_ack, busy} !== 4'b0000 || div_active !== 8'd1) begin
      n_fail++;
      $display("FAIL areset_now: got out=%b rise=%b ack=%b busy=%b act=%0d want out=0 rise=0 ack=0 busy=0 act=1",
               clk_out, clk_rise, cfg_ack, busy, div_active);
    end
    tick();
    rst = 1'b0; cfg_req = 1'b0; en = 1'b1;
    tick();
    n_tests++; if (clk_out !== 1'b0) begin n_fail++; $display("FAIL areset_idle_edge: got out=%b want 0", clk_out); end
    tick();
    n_tests++; if ({clk_out, clk_rise} !== 2'b11) begin n_fail++; $display("FAIL areset_div2: got out=%b rise=%b want out=1 rise=1", clk_out, clk_rise); end
    en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; cfg_req = 1'b0; div_val = 8'd0;
    test_reset();
    test_div2();
    test_idle_ratio();
    test_run_change();
    test_zero_early_drop();
    test_stop_mid_high();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
